// File: rtl/tlc_phase_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tlc_phase_scheduler
//  Purpose  : Two-street intersection phase scheduler. Sequences the lamps of
//             streets A and B through green / yellow / all-red phases, with
//             minimum and maximum green times. A latched pedestrian request
//             inserts an all-red WALK phase at the next all-red clearance.
//  Ports    : clk      - system clock, rising edge
//             reset_n  - asynchronous, active-low reset
//             Sa, Sb   - car present on street A / B (level)
//             P_req    - pedestrian button (pulse of >= 1 cycle latches)
//             Ga,Ya,Ra - street A lamps
//             Gb,Yb,Rb - street B lamps
//             W        - pedestrian WALK lamp
//             phase    - current state encoding (status/debug)
//  Revision : 1.0 - initial release
// ============================================================================
module tlc_phase_scheduler #(
    parameter int N      = 13,
    parameter int T_GMIN = 4000,
    parameter int T_GMAX = 8000,
    parameter int T_YEL  = 1000,
    parameter int T_AR   = 100,
    parameter int T_WALK = 2000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       Sa,
    input  logic       Sb,
    input  logic       P_req,
    output logic       Ga,
    output logic       Ya,
    output logic       Ra,
    output logic       Gb,
    output logic       Yb,
    output logic       Rb,
    output logic       W,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        A_GRN  = 3'd0,
        A_YEL  = 3'd1,
        RED_AB = 3'd2,
        B_GRN  = 3'd3,
        B_YEL  = 3'd4,
        RED_BA = 3'd5,
        WALK   = 3'd6
    } state_t;

    // Terminal counts: a state lasting T cycles exits when cnt == T-1.
    localparam logic [N-1:0] C_GMIN_LAST = N'(T_GMIN - 1);
    localparam logic [N-1:0] C_GMAX_LAST = N'(T_GMAX - 1);
    localparam logic [N-1:0] C_YEL_LAST  = N'(T_YEL - 1);
    localparam logic [N-1:0] C_AR_LAST   = N'(T_AR - 1);
    localparam logic [N-1:0] C_WALK_LAST = N'(T_WALK - 1);
    localparam logic [N-1:0] C_ONE       = N'(1);

    localparam logic C_LAST_A = 1'b0;
    localparam logic C_LAST_B = 1'b1;

    state_t         state_q,    state_d;
    logic [N-1:0]   cnt_q,      cnt_d;
    logic           ped_pend_q, ped_pend_d;
    logic           last_grn_q, last_grn_d;

    logic           w_gmin_done;
    logic           w_gmax_hit;
    logic           w_is_green;
    logic           w_demand_b;
    logic           w_leave_b;

    assign w_gmin_done = (cnt_q >= C_GMIN_LAST);
    assign w_gmax_hit  = (cnt_q == C_GMAX_LAST);
    assign w_is_green  = (state_q == A_GRN) || (state_q == B_GRN);
    assign w_demand_b  = Sb | ped_pend_q;
    assign w_leave_b   = ~Sb | Sa | ped_pend_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= A_GRN;
            cnt_q      <= '0;
            ped_pend_q <= 1'b0;
            last_grn_q <= C_LAST_A;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ped_pend_q <= ped_pend_d;
            last_grn_q <= last_grn_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        last_grn_d = last_grn_q;
        case (state_q)
            A_GRN: begin
                // Street A is the rest state: it only yields to demand,
                // and holds against contested demand until max green.
                if (w_gmin_done && w_demand_b && (~Sa || w_gmax_hit)) begin
                    state_d = A_YEL;
                end
            end
            A_YEL: begin
                if (cnt_q == C_YEL_LAST) begin
                    state_d    = RED_AB;
                    last_grn_d = C_LAST_A;
                end
            end
            RED_AB: begin
                if (cnt_q == C_AR_LAST) begin
                    state_d = ped_pend_q ? WALK : B_GRN;
                end
            end
            B_GRN: begin
                // Leave at min green once B traffic is gone; leave at max
                // green if B traffic remains but A or pedestrians wait.
                if (w_gmin_done && w_leave_b &&
                    (~Sb || ~(Sa | ped_pend_q) || w_gmax_hit)) begin
                    state_d = B_YEL;
                end
            end
            B_YEL: begin
                if (cnt_q == C_YEL_LAST) begin
                    state_d    = RED_BA;
                    last_grn_d = C_LAST_B;
                end
            end
            RED_BA: begin
                if (cnt_q == C_AR_LAST) begin
                    state_d = ped_pend_q ? WALK : A_GRN;
                end
            end
            WALK: begin
                // Resume alternation: serve the street that did not have
                // the last green.
                if (cnt_q == C_WALK_LAST) begin
                    state_d = (last_grn_q == C_LAST_A) ? B_GRN : A_GRN;
                end
            end
            default: begin
                state_d = A_GRN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Phase counter and pedestrian latch
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q + C_ONE;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (w_is_green && w_gmax_hit) begin
            cnt_d = cnt_q;
        end
    end

    always_comb begin
        ped_pend_d = ped_pend_q;
        if (state_q != WALK) begin
            // Entering WALK serves any request, including one arriving in
            // the same cycle, so the clear wins over the set.
            if (state_d == WALK) begin
                ped_pend_d = 1'b0;
            end else if (P_req) begin
                ped_pend_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Moore lamp decode from the state register only
    // ------------------------------------------------------------------
    always_comb begin
        Ga = 1'b0;
        Ya = 1'b0;
        Ra = 1'b1;
        Gb = 1'b0;
        Yb = 1'b0;
        Rb = 1'b1;
        W  = 1'b0;
        case (state_q)
            A_GRN: begin
                Ga = 1'b1;
                Ra = 1'b0;
            end
            A_YEL: begin
                Ya = 1'b1;
                Ra = 1'b0;
            end
            B_GRN: begin
                Gb = 1'b1;
                Rb = 1'b0;
            end
            B_YEL: begin
                Yb = 1'b1;
                Rb = 1'b0;
            end
            WALK: begin
                W = 1'b1;
            end
            default: begin
                W = 1'b0;
            end
        endcase
    end

    assign phase = state_q;

endmodule
`default_nettype wire

// File: tb/tb_tlc_phase_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tlc_phase_scheduler
//  Purpose  : Directed self-checking bench for tlc_phase_scheduler. Expected
//             phase transitions (cycle, phase) are queued as each scenario is
//             set up and popped as the DUT changes phase; lamp decode and
//             safety invariants are checked on every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tlc_phase_scheduler;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       Sa      = 1'b0;
    logic       Sb      = 1'b0;
    logic       P_req   = 1'b0;
    logic       Ga, Ya, Ra, Gb, Yb, Rb, W;
    logic [2:0] phase;

    tlc_phase_scheduler dut (
        .clk     (clk),
        .reset_n (reset_n),
        .Sa      (Sa),
        .Sb      (Sb),
        .P_req   (P_req),
        .Ga      (Ga),
        .Ya      (Ya),
        .Ra      (Ra),
        .Gb      (Gb),
        .Yb      (Yb),
        .Rb      (Rb),
        .W       (W),
        .phase   (phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [2:0] ph;
    } exp_t;

    exp_t       sb_q[$];
    int         total      = 0;
    int         bad        = 0;
    int         tick       = 0;
    int         t0         = 0;
    bit         mon_en     = 1'b0;
    logic [2:0] prev_phase = 3'd0;

    always @(posedge clk) tick <= tick + 1;

    function automatic int cyc_now();
        return tick - t0;
    endfunction

    // {Ga,Ya,Ra,Gb,Yb,Rb,W} for each phase
    function automatic logic [6:0] lamps_for(input logic [2:0] p);
        case (p)
            3'd0:    return 7'b1000010;
            3'd1:    return 7'b0100010;
            3'd2:    return 7'b0010010;
            3'd3:    return 7'b0011000;
            3'd4:    return 7'b0010100;
            3'd5:    return 7'b0010010;
            3'd6:    return 7'b0010011;
            default: return 7'b0010010;
        endcase
    endfunction

    function automatic logic inv_ok(input logic [6:0] l);
        logic ga, ya, ra, gb, yb, rb, w;
        {ga, ya, ra, gb, yb, rb, w} = l;
        return ((32'(ga) + 32'(ya) + 32'(ra)) == 32'd1) &&
               ((32'(gb) + 32'(yb) + 32'(rb)) == 32'd1) &&
               !((ga | ya) & (gb | yb)) &&
               (!w || (ra && rb));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h at cycle %0d",
                   tag, obs, exp, cyc_now());
        end
    endtask

    // Per-cycle monitor: lamp table, invariants, transition scoreboard
    always @(negedge clk) begin
        logic [6:0] lamps;
        exp_t       e;
        lamps = {Ga, Ya, Ra, Gb, Yb, Rb, W};
        chk("lamp_decode", 32'(lamps), 32'(lamps_for(phase)));
        chk("invariants", 32'(inv_ok(lamps)), 32'd1);
        if (mon_en && (phase !== prev_phase)) begin
            if (sb_q.size() == 0) begin
                chk("extra_transition", 32'(phase), 32'(prev_phase));
            end else begin
                e = sb_q.pop_front();
                chk("trans_cycle", 32'(cyc_now()), 32'(e.cyc));
                chk("trans_phase", 32'(phase), 32'(e.ph));
            end
        end
        prev_phase = phase;
    end

    task automatic wait_cyc(input int k);
        while (cyc_now() < k) @(negedge clk);
    endtask

    task automatic exp_tr(input int c, input logic [2:0] p);
        exp_t e;
        e.cyc = c;
        e.ph  = p;
        sb_q.push_back(e);
    endtask

    task automatic start_test();
        mon_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        Sa      = 1'b0;
        Sb      = 1'b0;
        P_req   = 1'b0;
        sb_q.delete();
        repeat (2) @(negedge clk);
        chk("reset_state", 32'({Ga, Ya, Ra, Gb, Yb, Rb, W, phase}), 32'(10'b1000010_000));
    endtask

    // Called at a negedge: cycle 0 is the interval before the first posedge
    task automatic release_rst();
        reset_n = 1'b1;
        t0      = tick;
        mon_en  = 1'b1;
    endtask

    task automatic end_test(input int end_cyc);
        wait_cyc(end_cyc);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        // ---- 1: idle, stays in A_GRN ----
        start_test();
        release_rst();
        end_test(20000);
        chk("idle_phase", 32'(phase), 32'd0);

        // ---- 2: Sb from cycle 10, Sa=0 ----
        start_test();
        exp_tr(4000, 3'd1);
        exp_tr(5000, 3'd2);
        exp_tr(5100, 3'd3);
        release_rst();
        wait_cyc(10);
        Sb = 1'b1;
        end_test(10000);
        chk("b_hold_gb", 32'(Gb), 32'd1);

        // ---- 3: contested demand, max-green alternation ----
        start_test();
        Sa = 1'b1;
        Sb = 1'b1;
        exp_tr(8000,  3'd1);
        exp_tr(9000,  3'd2);
        exp_tr(9100,  3'd3);
        exp_tr(17100, 3'd4);
        exp_tr(18100, 3'd5);
        exp_tr(18200, 3'd0);
        release_rst();
        end_test(18300);

        // ---- 4: one-cycle pedestrian request ----
        start_test();
        exp_tr(4000,  3'd1);
        exp_tr(5000,  3'd2);
        exp_tr(5100,  3'd6);
        exp_tr(7100,  3'd3);
        exp_tr(11100, 3'd4);
        exp_tr(12100, 3'd5);
        exp_tr(12200, 3'd0);
        release_rst();
        wait_cyc(500);
        P_req = 1'b1;
        wait_cyc(501);
        P_req = 1'b0;
        wait_cyc(6000);
        chk("walk_lamp", 32'({W, Ra, Rb}), 32'd7);
        end_test(12300);

        // ---- 5: demand drops at A_YEL entry, sequence still completes ----
        start_test();
        Sb = 1'b1;
        exp_tr(4000,  3'd1);
        exp_tr(5000,  3'd2);
        exp_tr(5100,  3'd3);
        exp_tr(9100,  3'd4);
        exp_tr(10100, 3'd5);
        exp_tr(10200, 3'd0);
        release_rst();
        wait_cyc(4000);
        Sb = 1'b0;
        end_test(10300);

        // ---- 6: async reset during B_YEL discards pending request ----
        start_test();
        Sb = 1'b1;
        exp_tr(4000, 3'd1);
        exp_tr(5000, 3'd2);
        exp_tr(5100, 3'd3);
        exp_tr(9100, 3'd4);
        release_rst();
        wait_cyc(5100);
        Sb = 1'b0;
        wait_cyc(6000);
        P_req = 1'b1;
        wait_cyc(6001);
        P_req = 1'b0;
        end_test(9500);
        chk("pre_reset_phase", 32'(phase), 32'd4);
        mon_en = 1'b0;
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_reset", 32'({Ga, Ya, Ra, Gb, Yb, Rb, W, phase}), 32'(10'b1000010_000));
        repeat (3) @(negedge clk);
        release_rst();
        end_test(4500);
        chk("no_walk_after_reset", 32'(phase), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
